// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants and the control-bundle type for the ID-stage main
// decoder and the ID/EX control register. The EX-stage ALU control decoder
// imports the same ALUOp and funct constants so both ends agree on encodings.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // EX/MEM/WB control bundle carried from ID into EX.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [5:0] funct;
  } ctrl_t;

  // A bubble is an all-zero bundle: no side effects anywhere downstream.
  localparam ctrl_t BUBBLE = '0;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/main_decoder.sv
// main_decoder: combinational MIPS-32 subset main control decoder.
// Ports:
//   opcode  in  6   instruction[31:26]
//   funct   in  6   instruction[5:0]
//   ctrl    out     decoded control bundle (BUBBLE when illegal)
//   illegal out 1   unlisted opcode, or R-type with an unsupported funct
module main_decoder
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = BUBBLE;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct_legal(funct)) begin
          ctrl.valid     = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = ALUOP_FUNCT;
          ctrl.funct     = funct;
        end else begin
          illegal = 1'b1;
        end
      end
      OP_LW: begin
        ctrl.valid     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.valid     = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.valid  = 1'b1;
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_BNE: begin
        ctrl.valid     = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.branch_ne = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctrl.valid     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      // Jump resolves in ID; EX only sees an occupied, side-effect-free slot.
      OP_J: ctrl.valid = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl.sv
// id_ex_ctrl: ID-stage main control decode fused with the control half of the
// ID/EX pipeline register, updated under hazard-unit control.
// Optional feature macro: CTRL_PERF_CNT_EN (adds perf_bubbles / perf_illegal).
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   id_instr, id_valid instruction in ID and its occupancy flag
//   hz_bubble, hz_hold hazard unit: insert bubble / freeze EX
//   br_flush          squash ID, EX receives a bubble (beats hz_hold)
//   id_jump           combinational jump indication in ID
//   ex_*              registered EX control bundle, ex_illegal flag
//   perf_bubbles, perf_illegal  (CTRL_PERF_CNT_EN only) event counters
// Valid semantics: ex_valid=1 marks an occupied EX slot holding a real
// instruction; ex_valid=0 is a bubble and every other ex_* control is 0.
// There is no backpressure: EX accepts a new bundle every non-hold edge.
module id_ex_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic        hz_bubble,
  input  logic        hz_hold,
  input  logic        br_flush,
  output logic        id_jump,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemtoReg,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_Branch,
  output logic        ex_BranchNe,
  output logic        ex_ALUSrc,
  output logic        ex_RegDst,
  output logic [1:0]  ex_ALUOp,
  output logic [5:0]  ex_funct,
  output logic        ex_illegal
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_illegal
`endif
);

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t ex_q, ex_d;
  logic  ill_q, ill_d;
  logic  load_bubble;

  // Register/shamt/immediate fields are not needed for control decode.
  logic  unused_fields;
  assign unused_fields = ^id_instr[25:6];

  main_decoder u_dec (
    .opcode  (id_instr[31:26]),
    .funct   (id_instr[5:0]),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign id_jump = id_valid && (id_instr[31:26] == OP_J);

  // Update priority: flush > hold > hz_bubble > empty ID > decoded bundle.
  always_comb begin
    ex_d        = ex_q;
    ill_d       = ill_q;
    load_bubble = 1'b0;
    if (br_flush) begin
      ex_d        = BUBBLE;
      ill_d       = 1'b0;
      load_bubble = 1'b1;
    end else if (hz_hold) begin
      ex_d  = ex_q;
      ill_d = ill_q;
    end else if (hz_bubble || !id_valid) begin
      ex_d        = BUBBLE;
      ill_d       = 1'b0;
      load_bubble = 1'b1;
    end else if (dec_illegal) begin
      ex_d        = BUBBLE;
      ill_d       = 1'b1;
      load_bubble = 1'b1;
    end else begin
      ex_d  = dec_ctrl;
      ill_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= BUBBLE;
      ill_q <= 1'b0;
    end else begin
      ex_q  <= ex_d;
      ill_q <= ill_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  // Counters only advance on load edges, so they freeze during hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubbles <= '0;
      perf_illegal <= '0;
    end else begin
      if (load_bubble)          perf_bubbles <= perf_bubbles + 32'd1;
      if (load_bubble && ill_d) perf_illegal <= perf_illegal + 32'd1;
    end
  end
`else
  logic unused_load_bubble;
  assign unused_load_bubble = load_bubble;
`endif

  assign ex_valid    = ex_q.valid;
  assign ex_RegWrite = ex_q.reg_write;
  assign ex_MemtoReg = ex_q.memto_reg;
  assign ex_MemRead  = ex_q.mem_read;
  assign ex_MemWrite = ex_q.mem_write;
  assign ex_Branch   = ex_q.branch;
  assign ex_BranchNe = ex_q.branch_ne;
  assign ex_ALUSrc   = ex_q.alu_src;
  assign ex_RegDst   = ex_q.reg_dst;
  assign ex_ALUOp    = ex_q.alu_op;
  assign ex_funct    = ex_q.funct;
  assign ex_illegal  = ill_q;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// tb_id_ex_ctrl: randomized + directed bench for id_ex_ctrl against a
// table-driven reference model of the decode and register priority rules.
module tb_id_ex_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr;
  logic        id_valid, hz_bubble, hz_hold, br_flush;
  logic        id_jump;
  logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite;
  logic        ex_Branch, ex_BranchNe, ex_ALUSrc, ex_RegDst;
  logic [1:0]  ex_ALUOp;
  logic [5:0]  ex_funct;
  logic        ex_illegal;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_bubbles, perf_illegal;
`endif

  id_ex_ctrl dut (
    .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid),
    .hz_bubble(hz_bubble), .hz_hold(hz_hold), .br_flush(br_flush),
    .id_jump(id_jump), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
    .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch),
    .ex_BranchNe(ex_BranchNe), .ex_ALUSrc(ex_ALUSrc), .ex_RegDst(ex_RegDst),
    .ex_ALUOp(ex_ALUOp), .ex_funct(ex_funct), .ex_illegal(ex_illegal)
`ifdef CTRL_PERF_CNT_EN
    , .perf_bubbles(perf_bubbles), .perf_illegal(perf_illegal)
`endif
  );

  // Observed bundle: valid, 8 controls (table order), ALUOp, funct, illegal.
  logic [17:0] obs;
  assign obs = {ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite,
                ex_Branch, ex_BranchNe, ex_ALUSrc, ex_RegDst, ex_ALUOp,
                ex_funct, ex_illegal};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          failures = 0;
  logic [17:0] exp_q[$];
  logic [17:0] m_state = '0;
  int unsigned m_bubbles = 0;
  int unsigned m_illegal = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode table.
  function automatic logic [17:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'b000000:
        if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
          return {1'b1, 8'b10000001, 2'b10, fn, 1'b0};
        else
          return 18'd1;
      6'b100011: return {1'b1, 8'b11100010, 2'b00, 6'd0, 1'b0};
      6'b101011: return {1'b1, 8'b00010010, 2'b00, 6'd0, 1'b0};
      6'b000100: return {1'b1, 8'b00001000, 2'b01, 6'd0, 1'b0};
      6'b000101: return {1'b1, 8'b00001100, 2'b01, 6'd0, 1'b0};
      6'b001000: return {1'b1, 8'b10000010, 2'b00, 6'd0, 1'b0};
      6'b000010: return {1'b1, 8'b00000000, 2'b00, 6'd0, 1'b0};
      default:   return 18'd1;
    endcase
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {op, mid, fn};
  endfunction

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [31:0] ins, input logic v,
                      input logic b, input logic h, input logic f);
    logic [17:0] nxt;
    @(negedge clk);
    id_instr  = ins;
    id_valid  = v;
    hz_bubble = b;
    hz_hold   = h;
    br_flush  = f;
    #1;
    check({tag, ".id_jump"}, 64'(id_jump), 64'(v && ins[31:26] == 6'b000010));
    nxt = m_state;
    if (f) nxt = '0;
    else if (h) nxt = m_state;
    else if (b || !v) nxt = '0;
    else nxt = ref_decode(ins);
    if (f || (!h && nxt[17] == 1'b0)) begin
      m_bubbles++;
      if (nxt[0]) m_illegal++;
    end
    m_state = nxt;
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    check({tag, ".bundle"}, 64'(obs), 64'(exp_q.pop_front()));
`ifdef CTRL_PERF_CNT_EN
    check({tag, ".perf_bubbles"}, 64'(perf_bubbles), 64'(m_bubbles));
    check({tag, ".perf_illegal"}, 64'(perf_illegal), 64'(m_illegal));
`endif
  endtask

  task automatic go(input string tag, input logic [31:0] ins);
    step(tag, ins, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] ops[7]    = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                            6'b000101, 6'b001000, 6'b000010};
  logic [5:0] fns[5]    = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                            6'b101010};

  initial begin
    reset = 1'b1;
    id_instr = '0; id_valid = 1'b0;
    hz_bubble = 1'b0; hz_hold = 1'b0; br_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.bundle", 64'(obs), 64'd0);
`ifdef CTRL_PERF_CNT_EN
    check("reset.perf_bubbles", 64'(perf_bubbles), 64'd0);
    check("reset.perf_illegal", 64'(perf_illegal), 64'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Counter scenario: 1 flush, 2 hz_bubble, 1 illegal, 2 holds.
    go("pc.add", mk(6'b000000, 6'b100000));
    step("pc.flush", mk(6'b100011, 6'd0), 1'b1, 1'b0, 1'b0, 1'b1);
    step("pc.bub1", mk(6'b100011, 6'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    step("pc.bub2", mk(6'b100011, 6'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    go("pc.ill", mk(6'b111111, 6'd0));
    check("pc.ill_flag", 64'(ex_illegal), 64'd1);
    step("pc.hold1", mk(6'b100011, 6'd0), 1'b1, 1'b0, 1'b1, 1'b0);
    step("pc.hold2", mk(6'b100011, 6'd0), 1'b1, 1'b0, 1'b1, 1'b0);
    check("pc.ill_held", 64'(ex_illegal), 64'd1);
`ifdef CTRL_PERF_CNT_EN
    check("pc.perf_bubbles", 64'(perf_bubbles), 64'd4);
    check("pc.perf_illegal", 64'(perf_illegal), 64'd1);
`endif
    go("pc.add2", mk(6'b000000, 6'b100000));
    check("pc.ill_cleared", 64'(ex_illegal), 64'd0);

    // Asynchronous reset mid-cycle with lw in EX.
    go("ar.lw", mk(6'b100011, 6'd0));
    check("ar.lw_memread", 64'(ex_MemRead), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("ar.cleared", 64'(obs), 64'd0);
`ifdef CTRL_PERF_CNT_EN
    check("ar.perf_bubbles", 64'(perf_bubbles), 64'd0);
`endif
    m_state = '0; m_bubbles = 0; m_illegal = 0;
    @(negedge clk);
    reset = 1'b0;

    // Directed stream.
    for (int i = 0; i < 5; i++) go("st.rtype", mk(6'b000000, fns[i]));
    go("st.lw", mk(6'b100011, 6'd5));
    check("st.lw_fields", 64'({ex_ALUOp, ex_MemRead, ex_MemtoReg, ex_ALUSrc, ex_funct}),
          64'({2'b00, 1'b1, 1'b1, 1'b1, 6'd0}));
    go("st.sw", mk(6'b101011, 6'd0));
    go("st.beq", mk(6'b000100, 6'd0));
    go("st.bne", mk(6'b000101, 6'd0));
    check("st.bne_fields", 64'({ex_ALUOp, ex_BranchNe}), 64'({2'b01, 1'b1}));
    go("st.addi", mk(6'b001000, 6'd0));
    go("st.j", mk(6'b000010, 6'd0));
    check("st.j_fields", 64'(obs), 64'({1'b1, 17'd0}));
    go("st.add", mk(6'b000000, 6'b100000));
    check("st.add_fields", 64'({ex_ALUOp, ex_funct, ex_RegDst}),
          64'({2'b10, 6'b100000, 1'b1}));

    // Load-use bubble then release.
    go("lu.lw", mk(6'b100011, 6'd0));
    step("lu.bubble", mk(6'b000000, 6'b100000), 1'b1, 1'b1, 1'b0, 1'b0);
    check("lu.bubble_zero", 64'(obs), 64'd0);
    go("lu.add", mk(6'b000000, 6'b100000));

    // Hold three cycles with sw in EX, then hold+flush.
    go("hd.sw", mk(6'b101011, 6'd0));
    for (int i = 0; i < 3; i++)
      step("hd.hold", mk(ops[i], fns[i]), 1'b1, 1'b0, 1'b1, 1'b0);
    check("hd.sw_kept", 64'({ex_valid, ex_MemWrite, ex_ALUSrc}), 64'(3'b111));
    step("hd.flush", mk(6'b100011, 6'd0), 1'b1, 1'b0, 1'b1, 1'b1);
    check("hd.flush_zero", 64'(obs), 64'd0);

    // Illegal opcode and illegal funct back to back.
    go("il.op", mk(6'b111111, 6'd0));
    go("il.fn", mk(6'b000000, 6'b000111));
    check("il.fn_flag", 64'(obs), 64'd1);
    go("il.add", mk(6'b000000, 6'b100000));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      step("rnd", mk(op, fn), $urandom_range(0, 9) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 9) == 0);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
